round_shift_pipe: RTL and testbench

//   Parametrised, pipelined successor to the fixed 10-bit round shifter in the acquire engine.
//   - Applies one runtime right shift to CHANNELS unsigned samples per beat (e.g. I/Q or code-phase magnitudes).
//   - Rounding is biased: add back the last bit shifted out. Result saturates to OUT_WIDTH.
//   - Sits between the coherent accumulator and the acquisition peak search, with valid/ready flow control on both sides.

---
 rtl/round_shift_pipe.sv | 128 ++++++++++++
 tb/tb_round_shift_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_shift_pipe.sv
// Two-stage round/saturate right shifter: S1 captures samples and shift, S2 holds the rounded result.
// Define ROUND_SHIFT_SAT_CNT_EN to build the saturation event counter; otherwise sat_count reads 0.
module round_shift_pipe #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 10,
  parameter int SHIFT_WIDTH = 5,
  parameter int CHANNELS    = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0]        in_shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]           out_sat,
  input  logic                          sat_clear,
  output logic [CNT_WIDTH-1:0]          sat_count
);

  localparam logic [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic                          r_s1_valid;
  logic [CHANNELS*IN_WIDTH-1:0]  r_s1_data;
  logic [SHIFT_WIDTH-1:0]        r_s1_shift;
  logic                          r_out_valid;
  logic [CHANNELS*OUT_WIDTH-1:0] r_out_data;
  logic [CHANNELS-1:0]           r_out_sat;

  logic                          w_s1_load;
  logic                          w_s2_load;
  logic [CHANNELS*OUT_WIDTH-1:0] w_res;
  logic [CHANNELS-1:0]           w_sat;

  // Returns {sat, value}. Shifting by s-1 first leaves the rounding bit in t[0].
  function automatic logic [OUT_WIDTH:0] f_round_sat(input logic [IN_WIDTH-1:0]    d,
                                                     input logic [SHIFT_WIDTH-1:0] s);
    logic [IN_WIDTH:0] t;
    logic [IN_WIDTH:0] r;
    t = '0;
    r = '0;
    if (s == '0) begin
      r = {1'b0, d};
    end else if (s <= SHIFT_WIDTH'(IN_WIDTH)) begin
      t = {1'b0, d} >> (s - SHIFT_WIDTH'(1));
      r = (t >> 1) + {{IN_WIDTH{1'b0}}, t[0]};
    end
    if (r > SAT_MAX) begin
      return {1'b1, {OUT_WIDTH{1'b1}}};
    end
    return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  always_comb begin
    w_res = '0;
    w_sat = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      {w_sat[ch], w_res[ch*OUT_WIDTH +: OUT_WIDTH]} =
        f_round_sat(r_s1_data[ch*IN_WIDTH +: IN_WIDTH], r_s1_shift);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shift <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data  <= in_data;
        r_s1_shift <= in_shift;
      end
    end
  end

  // Result registers only move when a real beat arrives, so they hold through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_res;
        r_out_sat  <= w_sat;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

`ifdef ROUND_SHIFT_SAT_CNT_EN
  logic [CNT_WIDTH-1:0] r_sat_count;
  logic                 w_sat_event;

  assign w_sat_event = r_out_valid && out_ready && (|r_out_sat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (sat_clear) begin
      r_sat_count <= '0;
    end else if (w_sat_event && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + CNT_WIDTH'(1);
    end
  end

  assign sat_count = r_sat_count;
`else
  logic w_unused;

  assign w_unused  = sat_clear;
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_round_shift_pipe.sv
// Directed bench for round_shift_pipe: rounding/saturation vectors, latency, backpressure,
// saturation counter and mid-stream reset, with an in-order scoreboard of hand-computed results.
module tb_round_shift_pipe;

`ifdef ROUND_SHIFT_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [1:0]  out_sat;
  logic        sat_clear;
  logic [15:0] sat_count;

  round_shift_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clear (sat_clear),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;
  logic obs_ov;
  logic obs_ir;
  logic [21:0] sb[$];

  localparam logic [31:0] SAT_BEAT = {16'h0400, 16'h0001};
  localparam logic [19:0] SAT_EXP  = {10'h3FF, 10'h001};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: apply inputs at the falling edge, then score whatever transfers at the next rising edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic rdy, input logic clr,
                       input logic [19:0] ed, input logic [1:0] es);
    logic [21:0] e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_shift  = s;
    out_ready = rdy;
    sat_clear = clr;
    #1;
    obs_ov = out_valid;
    obs_ir = in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e[19:0]));
        check("out_sat", 32'(out_sat), 32'(e[21:20]));
      end
    end
    if (in_valid && in_ready) begin
      n_acc++;
      sb.push_back({es, ed});
    end
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 5'd0, rdy, 1'b0, 20'h0, 2'b00);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1'b1);
    check("drain_empty", 32'(sb.size()), 32'd0);
    idle(1'b1);
  endtask

  task automatic beat(input logic [31:0] d, input logic [4:0] s,
                      input logic [19:0] ed, input logic [1:0] es);
    drive(1'b1, d, s, 1'b1, 1'b0, ed, es);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int o0;
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0;
    out_ready = 1'b0; sat_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: beat offered in cycle 10 appears in cycle 12 only.
    while (cyc < 9) idle(1'b1);
    beat({16'h0400, 16'h0155}, 5'd0, {10'h3FF, 10'h155}, 2'b10);
    idle(1'b1); check("lat_c11", 32'(obs_ov), 32'd0);
    idle(1'b1); check("lat_c12", 32'(obs_ov), 32'd1);
    idle(1'b1); check("lat_c13", 32'(obs_ov), 32'd0);

    // Rounding and saturation vectors, back to back.
    beat({16'h0400, 16'h0155}, 5'd0,  {10'h3FF, 10'h155}, 2'b10);
    beat({16'h0003, 16'h00FF}, 5'd1,  {10'h002, 10'h080}, 2'b00);
    beat({16'h0003, 16'h00FF}, 5'd2,  {10'h001, 10'h040}, 2'b00);
    beat({16'hFFFF, 16'hFFFF}, 5'd16, {10'h001, 10'h001}, 2'b00);
    beat({16'hFFFF, 16'hFFFF}, 5'd17, {10'h000, 10'h000}, 2'b00);
    beat({16'hFFFF, 16'hFFFF}, 5'd31, {10'h000, 10'h000}, 2'b00);
    beat({16'h0155, 16'hFFFF}, 5'd6,  {10'h005, 10'h3FF}, 2'b01);
    beat({16'h7FFF, 16'hFFFF}, 5'd10, {10'h020, 10'h040}, 2'b00);
    beat({16'h7FFF, 16'h4000}, 5'd15, {10'h001, 10'h001}, 2'b00);
    beat({16'h7FFF, 16'h8000}, 5'd16, {10'h000, 10'h001}, 2'b00);
    beat({16'h07FE, 16'h03FF}, 5'd1,  {10'h3FF, 10'h200}, 2'b00);
    beat({16'h07FF, 16'h0000}, 5'd1,  {10'h3FF, 10'h000}, 2'b10);
    beat({16'hFFFF, 16'hFFFF}, 5'd0,  {10'h3FF, 10'h3FF}, 2'b11);
    drain();

    // Backpressure: two beats fill the pipe, then release at full rate.
    a0 = n_acc;
    k = 1;
    repeat (5) begin
      drive(1'b1, {16'(16'h100 + k), 16'(k)}, 5'd0, 1'b0, 1'b0,
            {10'(10'h100 + k), 10'(k)}, 2'b00);
      k++;
    end
    check("bp_accepts", 32'(n_acc - a0), 32'd2);
    check("bp_in_ready", 32'(obs_ir), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'({10'h101, 10'h001}));
    o0 = n_out;
    repeat (6) begin
      drive(1'b1, {16'(16'h100 + k), 16'(k)}, 5'd0, 1'b1, 1'b0,
            {10'(10'h100 + k), 10'(k)}, 2'b00);
      k++;
    end
    check("bp_rate", 32'(n_out - o0), 32'd6);
    drain();
    idle(1'b1);
    check("idle_hold", 32'(out_data), 32'({10'h10B, 10'h00B}));

    // Saturation counter.
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 20'h0, 2'b00);
    idle(1'b1);
    check("cnt_clear", 32'(sat_count), 32'd0);
    beat(SAT_BEAT, 5'd0, SAT_EXP, 2'b10);
    beat({16'h0010, 16'h0020}, 5'd0, {10'h010, 10'h020}, 2'b00);
    beat(SAT_BEAT, 5'd0, SAT_EXP, 2'b10);
    beat(SAT_BEAT, 5'd0, SAT_EXP, 2'b10);
    drain();
    check("cnt_3", 32'(sat_count), CNT_EN ? 32'd3 : 32'd0);
    drive(1'b1, SAT_BEAT, 5'd0, 1'b0, 1'b0, SAT_EXP, 2'b10);
    idle(1'b0);
    idle(1'b0);
    check("cnt_stalled", 32'(sat_count), CNT_EN ? 32'd3 : 32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 20'h0, 2'b00);
    idle(1'b1);
    check("cnt_clr_priority", 32'(sat_count), 32'd0);
    for (int i = 0; i < 65540; i++) beat(SAT_BEAT, 5'd0, SAT_EXP, 2'b10);
    drain();
    check("cnt_saturate", 32'(sat_count), CNT_EN ? 32'hFFFF : 32'd0);

    // Reset with two beats in flight.
    drive(1'b1, SAT_BEAT, 5'd0, 1'b0, 1'b0, SAT_EXP, 2'b10);
    drive(1'b1, {16'h0002, 16'h0003}, 5'd0, 1'b0, 1'b0, {10'h002, 10'h003}, 2'b00);
    check("mid_in_flight", 32'(sb.size()), 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_sat", 32'(out_sat), 32'd0);
    check("mid_rst_sat_count", 32'(sat_count), 32'd0);
    sb.delete();
    rst = 1'b0;
    o0 = n_out;
    repeat (6) idle(1'b1);
    check("mid_no_stale", 32'(n_out - o0), 32'd0);
    check("mid_in_ready", 32'(obs_ir), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
